// File: rtl/stereo_addsub_ctrl.sv
// FM stereo matrix sequencer: pops (L+R)/(L-R) pairs and writes left/right samples
// through one time-shared add/subtract unit.
module stereo_addsub_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  lpr_dout,
  input  logic                   lpr_empty,
  output logic                   lpr_rd_en,
  input  logic [DATA_WIDTH-1:0]  lmr_dout,
  input  logic                   lmr_empty,
  output logic                   lmr_rd_en,
  output logic [DATA_WIDTH-1:0]  left_din,
  input  logic                   left_full,
  output logic                   left_wr_en,
  output logic [DATA_WIDTH-1:0]  right_din,
  input  logic                   right_full,
  output logic                   right_wr_en,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] pair_count
);

  localparam int unsigned EXT_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                   both_avail;
  logic                   au_sub;
  logic [EXT_W-1:0]       a_ext, b_ext, au_sum;
  logic [DATA_WIDTH-1:0]  au_res;

  assign both_avail = !lpr_empty && !lmr_empty;
  assign pair_count = cnt_q;

  // Single shared adder: one extra bit of headroom, then floor-halving via the dropped LSB
  assign au_sub = (state_q == S_RIGHT);
  assign a_ext  = {a_q[DATA_WIDTH-1], a_q};
  assign b_ext  = {b_q[DATA_WIDTH-1], b_q};
  assign au_sum = au_sub ? (a_ext - b_ext) : (a_ext + b_ext);
  assign au_res = au_sum[EXT_W-1:1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    lpr_rd_en   = 1'b0;
    lmr_rd_en   = 1'b0;
    left_wr_en  = 1'b0;
    right_wr_en = 1'b0;
    left_din    = '0;
    right_din   = '0;
    busy        = 1'b0;

    // Strobes are suppressed during reset so nothing is popped or written that cycle
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          if (both_avail) begin
            lpr_rd_en = 1'b1;
            lmr_rd_en = 1'b1;
            a_d       = lpr_dout;
            b_d       = lmr_dout;
            state_d   = S_LEFT;
          end
        end
        S_LEFT: begin
          busy     = 1'b1;
          left_din = au_res;
          if (!left_full) begin
            left_wr_en = 1'b1;
            state_d    = S_RIGHT;
          end
        end
        S_RIGHT: begin
          busy      = 1'b1;
          right_din = au_res;
          if (!right_full) begin
            right_wr_en = 1'b1;
            cnt_d       = cnt_q + COUNT_WIDTH'(1);
            // Recapture in the same cycle to sustain one pair every two cycles
            if (both_avail) begin
              lpr_rd_en = 1'b1;
              lmr_rd_en = 1'b1;
              a_d       = lpr_dout;
              b_d       = lmr_dout;
              state_d   = S_LEFT;
            end else begin
              state_d   = S_FETCH;
            end
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_addsub_ctrl.sv
// Self-checking bench for stereo_addsub_ctrl with FWFT input FIFO models and
// output capture queues.
module tb_stereo_addsub_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] lpr_dout, lmr_dout, left_din, right_din;
  logic          lpr_empty, lmr_empty, lpr_rd_en, lmr_rd_en;
  logic          left_full, right_full, left_wr_en, right_wr_en, busy;
  logic [CW-1:0] pair_count;

  stereo_addsub_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .lpr_dout(lpr_dout), .lpr_empty(lpr_empty), .lpr_rd_en(lpr_rd_en),
    .lmr_dout(lmr_dout), .lmr_empty(lmr_empty), .lmr_rd_en(lmr_rd_en),
    .left_din(left_din), .left_full(left_full), .left_wr_en(left_wr_en),
    .right_din(right_din), .right_full(right_full), .right_wr_en(right_wr_en),
    .busy(busy), .pair_count(pair_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] lpr;
    logic [DW-1:0] lmr;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_cnt;

  logic [DW-1:0] lpr_q[$], lmr_q[$], left_cap[$], right_cap[$];

  // Strobes as seen mid-cycle; the FIFO model acts on them after the next rising edge
  logic          s_lpr_rd = 1'b0, s_lmr_rd = 1'b0, s_lw = 1'b0, s_rw = 1'b0;
  logic          s_lfull = 1'b0, s_rfull = 1'b0;
  logic [DW-1:0] s_ld = '0, s_rd = '0;

  always @(negedge clock) begin
    s_lpr_rd = lpr_rd_en;
    s_lmr_rd = lmr_rd_en;
    s_lw     = left_wr_en;
    s_rw     = right_wr_en;
    s_ld     = left_din;
    s_rd     = right_din;
    s_lfull  = left_full;
    s_rfull  = right_full;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    lpr_empty = (lpr_q.size() == 0);
    lmr_empty = (lmr_q.size() == 0);
    lpr_dout  = lpr_empty ? '0 : lpr_q[0];
    lmr_dout  = lmr_empty ? '0 : lmr_q[0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (s_lpr_rd) begin
      if (lpr_q.size() == 0) check("pop_empty_lpr", 64'(s_lpr_rd), 64'(0));
      else void'(lpr_q.pop_front());
    end
    if (s_lmr_rd) begin
      if (lmr_q.size() == 0) check("pop_empty_lmr", 64'(s_lmr_rd), 64'(0));
      else void'(lmr_q.pop_front());
    end
    if (s_lw) begin
      if (s_lfull) check("write_when_full_left", 64'(s_lw), 64'(0));
      left_cap.push_back(s_ld);
    end
    if (s_rw) begin
      if (s_rfull) check("write_when_full_right", 64'(s_rw), 64'(0));
      right_cap.push_back(s_rd);
    end
    refresh();
  endtask

  task automatic push(input logic [DW-1:0] p, input logic [DW-1:0] m);
    lpr_q.push_back(p);
    lmr_q.push_back(m);
    refresh();
  endtask

  // Waits for one complete pair and compares it against the expected samples
  task automatic wait_pair(input string name, input logic [DW-1:0] el, input logic [DW-1:0] er);
    int n = 0;
    while (right_cap.size() == 0 && n < 12) begin
      tick();
      n++;
    end
    if (right_cap.size() == 0 || left_cap.size() == 0) begin
      check({name, "_timeout"}, 64'(right_cap.size()), 64'(1));
    end else begin
      check({name, "_left"},  64'(left_cap.pop_front()),  64'(el));
      check({name, "_right"}, 64'(right_cap.pop_front()), 64'(er));
    end
  endtask

  function automatic logic [DW-1:0] gold(input logic [DW-1:0] p, input logic [DW-1:0] m,
                                         input bit sub);
    longint s;
    s = sub ? (longint'($signed(p)) - longint'($signed(m)))
            : (longint'($signed(p)) + longint'($signed(m)));
    return DW'(s >>> 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[7];
    logic [DW-1:0] sl[8], sm[8];

    vecs[0] = '{32'd3,         32'd0,         32'd1,         32'd1};
    vecs[1] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  32'h7FFFFFFF,  32'h0};
    vecs[2] = '{32'h80000000,  32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000000};
    vecs[3] = '{32'hFFFFFFFD,  32'd0,         32'hFFFFFFFE,  32'hFFFFFFFE};
    vecs[4] = '{32'd5,         32'hFFFFFFFE,  32'd1,         32'd3};
    vecs[5] = '{32'h80000000,  32'h80000000,  32'h80000000,  32'h0};
    vecs[6] = '{32'd1,         32'd2,         32'd1,         32'hFFFFFFFF};

    reset = 1'b1; left_full = 1'b0; right_full = 1'b0;
    refresh();
    tick(); tick();
    @(negedge clock);
    check("rst_rd_en",   64'({lpr_rd_en, lmr_rd_en}),   64'(0));
    check("rst_wr_en",   64'({left_wr_en, right_wr_en}), 64'(0));
    check("rst_din",     64'({left_din, right_din}),     64'(0));
    check("rst_busy",    64'(busy),       64'(0));
    check("rst_count",   64'(pair_count), 64'(0));
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("idle_no_pop", 64'({lpr_rd_en, lmr_rd_en}), 64'(0));

    // Basic latency: 100/40 -> left 70 one cycle later, right 30 the cycle after
    tick();
    push(32'd100, 32'd40);
    @(negedge clock);
    check("lat_pop",      64'({lpr_rd_en, lmr_rd_en}), 64'(2'b11));
    tick(); @(negedge clock);
    check("lat_left_wr",  64'({left_wr_en, right_wr_en}), 64'(2'b10));
    check("lat_left_din", 64'(left_din), 64'(70));
    check("lat_busy",     64'(busy), 64'(1));
    tick(); @(negedge clock);
    check("lat_right_wr",  64'({left_wr_en, right_wr_en}), 64'(2'b01));
    check("lat_right_din", 64'(right_din), 64'(30));
    tick(); @(negedge clock);
    check("lat_busy_done", 64'(busy), 64'(0));
    check("lat_count",     64'(pair_count), 64'(1));
    exp_cnt = 16'd1;
    left_cap.delete(); right_cap.delete();

    // Rounding and extreme-value table
    for (int i = 0; i < 7; i++) begin
      tick();
      push(vecs[i].lpr, vecs[i].lmr);
      wait_pair($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
      exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clock);
    check("vec_count", 64'(pair_count), 64'(exp_cnt));

    // Eight prefilled pairs stream at one write per cycle, alternating left/right
    tick();
    for (int i = 0; i < 8; i++) begin
      sl[i] = $urandom();
      sm[i] = $urandom();
      push(sl[i], sm[i]);
    end
    @(negedge clock);
    check("stream_first_pop", 64'({lpr_rd_en, lmr_rd_en}), 64'(2'b11));
    for (int c = 1; c <= 16; c++) begin
      tick(); @(negedge clock);
      check($sformatf("stream_wr_c%0d", c), 64'({left_wr_en, right_wr_en}),
            (c % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
      check($sformatf("stream_pop_c%0d", c), 64'({lpr_rd_en, lmr_rd_en}),
            (c % 2 == 0 && c < 16) ? 64'(2'b11) : 64'(0));
    end
    tick();
    check("stream_nleft",  64'(left_cap.size()),  64'(8));
    check("stream_nright", 64'(right_cap.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (left_cap.size() > 0)
        check($sformatf("stream_left%0d", i),  64'(left_cap.pop_front()),  64'(gold(sl[i], sm[i], 1'b0)));
      if (right_cap.size() > 0)
        check($sformatf("stream_right%0d", i), 64'(right_cap.pop_front()), 64'(gold(sl[i], sm[i], 1'b1)));
    end
    exp_cnt = exp_cnt + 16'd8;
    @(negedge clock);
    check("stream_count", 64'(pair_count), 64'(exp_cnt));

    // Backpressure: left held 5 cycles, then right held 3, with a second pair queued
    tick();
    left_full = 1'b1;
    push(32'd11, 32'd5);
    @(negedge clock);
    check("bp_pop", 64'({lpr_rd_en, lmr_rd_en}), 64'(2'b11));
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) push(32'hFFFFFFF9, 32'd3);
      @(negedge clock);
      check($sformatf("bp_lhold%0d", k),
            64'({left_wr_en, right_wr_en, lpr_rd_en, lmr_rd_en, busy}), 64'(5'b00001));
      check($sformatf("bp_ldin%0d", k), 64'(left_din), 64'(8));
    end
    tick();
    left_full = 1'b0; right_full = 1'b1;
    @(negedge clock);
    check("bp_left_rel", 64'({left_wr_en, left_din}), {31'd0, 1'b1, 32'd8});
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clock);
      check($sformatf("bp_rhold%0d", k),
            64'({left_wr_en, right_wr_en, lpr_rd_en, lmr_rd_en}), 64'(0));
      check($sformatf("bp_rdin%0d", k), 64'(right_din), 64'(3));
    end
    tick();
    right_full = 1'b0;
    @(negedge clock);
    check("bp_right_rel", 64'({right_wr_en, right_din}), {31'd0, 1'b1, 32'd3});
    check("bp_b2b_pop",   64'({lpr_rd_en, lmr_rd_en}), 64'(2'b11));
    tick(); tick(); tick();
    check("bp_nleft", 64'(left_cap.size()), 64'(2));
    check("bp_nright", 64'(right_cap.size()), 64'(2));
    if (left_cap.size() == 2 && right_cap.size() == 2) begin
      check("bp_left0",  64'(left_cap[0]),  64'(32'd8));
      check("bp_right0", 64'(right_cap[0]), 64'(32'd3));
      check("bp_left1",  64'(left_cap[1]),  64'(32'hFFFFFFFE));
      check("bp_right1", 64'(right_cap[1]), 64'(32'hFFFFFFFB));
    end
    left_cap.delete(); right_cap.delete();
    exp_cnt = exp_cnt + 16'd2;
    @(negedge clock);
    check("bp_count", 64'(pair_count), 64'(exp_cnt));

    // Imbalance: L+R samples alone never trigger a pop
    tick();
    lpr_q.push_back(32'd10); lpr_q.push_back(32'd20); lpr_q.push_back(32'd30);
    refresh();
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check($sformatf("imb_nopop%0d", k), 64'({lpr_rd_en, lmr_rd_en}), 64'(0));
      tick();
    end
    lmr_q.push_back(32'd4);
    refresh();
    @(negedge clock);
    check("imb_pop", 64'({lpr_rd_en, lmr_rd_en}), 64'(2'b11));
    wait_pair("imb", 32'd7, 32'd3);
    for (int k = 0; k < 5; k++) begin
      tick(); @(negedge clock);
      check($sformatf("imb_after%0d", k), 64'({lpr_rd_en, lmr_rd_en}), 64'(0));
    end
    check("imb_lpr_left", 64'(lpr_q.size()), 64'(2));
    exp_cnt = exp_cnt + 16'd1;
    check("imb_count", 64'(pair_count), 64'(exp_cnt));
    lpr_q.delete();
    refresh();

    // Reset while a captured pair sits in S_RIGHT discards its right sample
    tick();
    push(32'd50, 32'd10);
    @(negedge clock);
    check("rmid_pop", 64'({lpr_rd_en, lmr_rd_en}), 64'(2'b11));
    tick(); @(negedge clock);
    check("rmid_left", 64'({left_wr_en, left_din}), {31'd0, 1'b1, 32'd30});
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("rmid_rst_out", 64'({right_wr_en, right_din, busy}), 64'(0));
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rmid_count", 64'(pair_count), 64'(0));
    check("rmid_idle",  64'({busy, lpr_rd_en, lmr_rd_en}), 64'(0));
    tick(); tick();
    check("rmid_no_right", 64'(right_cap.size()), 64'(0));
    check("rmid_one_left", 64'(left_cap.size()),  64'(1));
    left_cap.delete();
    push(32'd9, 32'hFFFFFFFF);
    wait_pair("rmid_next", 32'd4, 32'd5);
    @(negedge clock);
    check("rmid_next_count", 64'(pair_count), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
